// File: rtl/sk9822_receiver_if.sv
// Wishbone data-bus bundle for the SK9822 receiver.
// The CPU side is the master; the receiver is the slave.
interface sk9822_receiver_if;
  logic        cyc;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic [31:0] rdt;

  modport master (output cyc, we, adr, dat, input ack, rdt);
  modport slave  (input cyc, we, adr, dat, output ack, rdt);
endinterface

// File: rtl/sk9822_receiver.sv
// SK9822/APA102 string receiver: rebuilds start/LED/end frames from an external
// clock/data pair and exposes the captured LED words over Wishbone.
module sk9822_receiver #(
  parameter logic [7:0] ADDR    = 8'h00,
  parameter int         NLEDS   = 12,
  parameter int         TIMEOUT = 1024
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  sk9822_receiver_if.slave    bus,
  input  logic                led_ck,
  input  logic                led_data,
  output logic                frame_irq
);

  localparam int          IW     = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  NLEDS4 = 4'(NLEDS);

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_e;

  logic [2:0]    ckSync_q;
  logic [1:0]    dataSync_q;

  logic [31:0]   shift_q, shift_d;
  logic [4:0]    bitCnt_q, bitCnt_d;
  logic [IW-1:0] idleCnt_q, idleCnt_d;
  state_e        state_q, state_d;
  logic [3:0]    ledIdx_q, ledIdx_d;
  logic [15:0]   frameCnt_q, frameCnt_d;
  logic [7:0]    errCnt_q, errCnt_d;
  logic [3:0]    lastCnt_q, lastCnt_d;
  logic          irq_q, irq_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;

  logic [31:0]   ram_q [NLEDS];

  logic          sample;
  logic          dataBit;
  logic [31:0]   shiftNext;
  logic          sel;
  logic [3:0]    wordIdx;
  logic          busStart;
  logic          clrReq;
  logic          timeoutHit;
  logic          ramWe;
  logic [31:0]   status;
  logic [31:0]   readData;
  logic          unusedBus;

  // Clock and data go through identical 2-FF chains so the sampled bit lines up with its edge.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      ckSync_q   <= '0;
      dataSync_q <= '0;
    end else begin
      ckSync_q   <= {ckSync_q[1:0], led_ck};
      dataSync_q <= {dataSync_q[0], led_data};
    end
  end

  assign sample    = ckSync_q[1] & ~ckSync_q[2];
  assign dataBit   = dataSync_q[1];
  assign shiftNext = {shift_q[30:0], dataBit};

  assign sel        = (bus.adr[31:24] == ADDR);
  assign wordIdx    = bus.adr[5:2];
  assign busStart   = bus.cyc & sel & ~ack_q;
  assign clrReq     = busStart & bus.we & (wordIdx == 4'd15);
  assign timeoutHit = ~sample & (idleCnt_q == IW'(TIMEOUT - 1));
  assign unusedBus  = ^{bus.dat, bus.adr[23:6], bus.adr[1:0]};

  assign status = {frameCnt_q, errCnt_q, 3'b000, (state_q == FRAME), lastCnt_q};

  always_comb begin
    readData = '0;
    if (wordIdx < NLEDS4) begin
      readData = ram_q[wordIdx];
    end else if (wordIdx == 4'd14) begin
      readData = status;
    end
  end

  // Next-state logic: a bus clear overrides everything, then timeout, then bit decoding.
  always_comb begin
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    idleCnt_d  = idleCnt_q;
    state_d    = state_q;
    ledIdx_d   = ledIdx_q;
    frameCnt_d = frameCnt_q;
    errCnt_d   = errCnt_q;
    lastCnt_d  = lastCnt_q;
    irq_d      = 1'b0;
    ramWe      = 1'b0;

    if (sample) begin
      shift_d   = shiftNext;
      bitCnt_d  = bitCnt_q + 5'd1;
      idleCnt_d = '0;
    end else if (idleCnt_q != IW'(TIMEOUT)) begin
      idleCnt_d = idleCnt_q + IW'(1);
    end

    if (clrReq) begin
      frameCnt_d = '0;
      errCnt_d   = '0;
      lastCnt_d  = '0;
      state_d    = HUNT;
    end else if (timeoutHit) begin
      state_d  = HUNT;
      bitCnt_d = '0;
    end else if (sample) begin
      case (state_q)
        HUNT: begin
          if (shiftNext == 32'h0000_0000) begin
            state_d  = FRAME;
            bitCnt_d = '0;
            ledIdx_d = '0;
          end
        end
        FRAME: begin
          if (bitCnt_q == 5'd31) begin
            // The all-ones test must precede the header test: an end frame also starts with 111.
            if (shiftNext == 32'h0000_0000) begin
              ledIdx_d = '0;
            end else if (shiftNext == 32'hFFFF_FFFF) begin
              lastCnt_d  = ledIdx_q;
              frameCnt_d = frameCnt_q + 16'd1;
              irq_d      = 1'b1;
              state_d    = HUNT;
            end else if (shiftNext[31:29] == 3'b111) begin
              ramWe = (ledIdx_q < NLEDS4);
              if (ledIdx_q != 4'd15) begin
                ledIdx_d = ledIdx_q + 4'd1;
              end
            end else begin
              if (errCnt_q != 8'hFF) begin
                errCnt_d = errCnt_q + 8'd1;
              end
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    ack_d = busStart;
    rdt_d = (busStart & ~bus.we) ? readData : 32'h0000_0000;
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      shift_q    <= '0;
      bitCnt_q   <= '0;
      idleCnt_q  <= '0;
      state_q    <= HUNT;
      ledIdx_q   <= '0;
      frameCnt_q <= '0;
      errCnt_q   <= '0;
      lastCnt_q  <= '0;
      irq_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdt_q      <= '0;
    end else begin
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      idleCnt_q  <= idleCnt_d;
      state_q    <= state_d;
      ledIdx_q   <= ledIdx_d;
      frameCnt_q <= frameCnt_d;
      errCnt_q   <= errCnt_d;
      lastCnt_q  <= lastCnt_d;
      irq_q      <= irq_d;
      ack_q      <= ack_d;
      rdt_q      <= rdt_d;
    end
  end

  // RAM keeps its contents across reset; a same-cycle bus read sees the old word.
  always_ff @(posedge wb_clk) begin
    if (wb_rst && ramWe) begin
      ram_q[ledIdx_q] <= shiftNext;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdt   = rdt_q;
  assign frame_irq = irq_q;

endmodule

// File: doc/sk9822_receiver.md
Name: sk9822_receiver

Overview:
- Receive-side counterpart of the SK9822/APA102 LED string driver.
- Samples an external LED clock/data pair and reconstructs start, LED and end frames.
- Stores each received LED word in a small RAM that the CPU reads over the Wishbone data bus.
- Used for loopback verification of the LED driver and for sniffing LED strings on the board.

Parameters:
ADDR, 0, 8-bit chip-select value compared against wb_dbus_adr[31:24]
NLEDS, 12, LED words stored per frame (max 14)
TIMEOUT, 1024, wb_clk cycles without a rising led_ck edge before the receiver resynchronises

Ports:
wb_clk  input  1  system clock
wb_rst  input  1  synchronous reset, active-low (0 = reset)
wb_dbus_cyc  input  1  bus cycle
wb_dbus_we  input  1  write enable
wb_dbus_adr  input  32  address; [31:24] chip select, [5:2] word index
wb_dbus_dat  input  32  write data (ignored apart from the write strobe)
ack  output  1  single-cycle bus acknowledge
rdt  output  32  read data, valid while ack is high
led_ck  input  1  external LED clock, asynchronous to wb_clk
led_data  input  1  external LED data, asynchronous to wb_clk
frame_irq  output  1  one-cycle pulse when a valid end frame completes

Behaviour:
Input path
- led_ck and led_data each pass through a 2-FF synchroniser; the two paths are matched.
- A bit is sampled on the first cycle after a synchronised 0->1 transition of led_ck (edge detect with a 3rd FF).
- The bit shifts into a 32-bit register, MSB first.
- led_ck high period must be >= 2 wb_clk cycles; slower clocks are fine, faster is out of scope.

Bit and frame counting
- A 5-bit bit counter increments per sampled bit. A word is complete when it wraps 31->0.
- An idle counter resets on every sampled edge. When it reaches TIMEOUT: state -> HUNT, bit counter = 0, no error is counted.

State machine (HUNT, FRAME)
- HUNT: on every sampled bit, test the last 32 bits. If they are all 0: -> FRAME, bit counter = 0, led_idx = 0.
- FRAME, on each completed word w:
  - w == 0x00000000: repeated start frame; led_idx = 0, stay in FRAME.
  - w[31:29] == 3'b111: LED word. If led_idx < NLEDS, write w to RAM[led_idx]. led_idx increments and saturates at 15.
  - w == 0xFFFFFFFF: end frame. Latch last_count = led_idx. frame_count += 1 (16-bit, wraps). Pulse frame_irq for 1 cycle. -> HUNT.
  - Any other value: err_count += 1 (8-bit, saturates at 255), -> HUNT.
- 0xFFFFFFFF is checked before the 111 header, so an end frame is never stored as an LED word.

Bus interface
- Chip select: sel = (wb_dbus_adr[31:24] == ADDR).
- Ack is registered: ack <= wb_dbus_cyc & sel & ~ack. This gives one ack per access, one cycle after cyc. ack is never high two cycles in a row.
- Read map, by word index wb_dbus_adr[5:2]:
  - 0..NLEDS-1: RAM word.
  - 14: status = {frame_count[15:0], err_count[7:0], 3'b0, state==FRAME, last_count[3:0]}.
  - All other indices: 0.
- rdt is registered in the same cycle ack is set, and holds 0 when ack is low.
- Write to index 15 (data ignored): clears frame_count, err_count and last_count, forces HUNT. Writes to any other index are acked and ignored.
- If a write-to-15 and a word completion happen in the same cycle, the write wins.
- RAM write by the receiver and RAM read by the bus in the same cycle at the same address: rdt returns the old word.

Reset (wb_rst == 0 at a clock edge)
- Outputs: ack = 0, rdt = 0, frame_irq = 0.
- State = HUNT. All counters, the shift register and led_idx = 0. Synchroniser FFs = 0.
- RAM contents are not cleared.
- Reset mid-frame discards the partial word, and no error is counted.

Test Plan:
1. Drive 32 zero bits, then LED words 0xE1000001..0xE100000C, then 0xFFFFFFFF, at led_ck = wb_clk/16 -> frame_irq pulses once. Read idx 0 = 0xE1000001 and idx 11 = 0xE100000C. Status = 0x0001_00_0C.
2. Start frame, 0xE0000005, then 0x12345678 -> err_count = 1, state HUNT, RAM[0] = 0xE0000005, no frame_irq.
3. Start frame, 2 LED words, then led_ck idle for TIMEOUT+10 cycles, then a full 12-LED frame -> frame_count = 1, last_count = 12, err_count = 0.
4. Start frame, 14 LED words, end frame -> RAM[0..11] updated, words 12/13 discarded, last_count = 14.
5. Hold cyc = 1 with ADDR matching for 6 cycles -> ack high on cycles 2, 4 and 6 only. Non-matching ADDR -> ack never asserts.
6. Assert wb_rst = 0 mid-LED-word, then deassert -> status reads 0. The next full frame decodes correctly and earlier RAM contents persist until overwritten.
